// File: rtl/gate_pkg.sv
// Shared definitions for the gate library checkers: FSM state encoding and
// reference truth tables for the 2-input library gates.
package gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit k is the expected gate output when the input vector equals k.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_truth_checker.sv
// Exhaustive stimulus-and-check engine for small combinational gates: walks every
// input vector in ascending order, samples the gate after a settle time, and reports.
module gate_truth_checker
  import gate_pkg::*;
#(
  parameter int                     N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = TT_AND2,
  parameter int                     SETTLE = 2,
  parameter int                     ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [(1<<N_IN)-1:0]   fail_vec
);

  localparam int                NV          = 1 << N_IN;
  localparam int                CW          = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   STIM_LAST   = N_IN'(NV - 1);
  localparam logic [NV-1:0]     TT          = TRUTH;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [N_IN-1:0]    stim_q;
  logic [ERR_W-1:0]   err_q;
  logic [NV-1:0]      fail_q;
  logic               pass_q;
  logic               mismatch;
  logic               last_vec;

  assign mismatch = (dut_out != TT[stim_q]);
  assign last_vec = (stim_q == STIM_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_vec ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (start) state_d = ST_DRIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
    pass = pass_q && (state_q == ST_DONE);
  end

  // The verdict is captured on the final SAMPLE edge so that a failing last
  // vector is already reflected when done first rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      stim_q <= '0;
      err_q  <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt_q  <= '0;
            stim_q <= '0;
            err_q  <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
          end
        end
        ST_DRIVE: cnt_q <= cnt_q + CW'(1);
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_q[stim_q] <= 1'b1;
            if (!(&err_q)) err_q <= err_q + ERR_W'(1);
          end
          if (last_vec) begin
            pass_q <= (err_q == '0) && !mismatch;
          end else begin
            stim_q <= stim_q + N_IN'(1);
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stim      = stim_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench for gate_truth_checker: models several gate behaviours on
// the DUT pins and checks stim sequencing, run length and the reported results.
module tb_gate_truth_checker;
  import gate_pkg::*;

  typedef struct {
    string      name;
    int         mode;
    int         exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
    int         pulse_at;
  } vec_t;

  typedef struct {
    logic [7:0] err;
    logic [3:0] fail;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] stim;
  logic       dut_out;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;
  int         mode = 0;

  logic       start2 = 1'b0;
  logic [1:0] stim2;
  logic       dut_out2;
  logic       busy2, done2, pass2;
  logic [0:0] err_count2;
  logic [3:0] fail_vec2;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  gate_truth_checker #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_truth_checker #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE(2), .ERR_W(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start(start2), .stim(stim2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .fail_vec(fail_vec2)
  );

  function automatic logic gate_model(input int m, input logic [1:0] s);
    case (m)
      0:       return s[1] & s[0];
      1:       return 1'b0;
      2:       return s[1] | s[0];
      3:       return s[1] ^ s[0];
      default: return ~(s[1] & s[0]);
    endcase
  endfunction

  always_comb dut_out  = gate_model(mode, stim);
  always_comb dut_out2 = ~(stim2[1] & stim2[0]);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full run: pulse start, follow stim each busy cycle, compare against the scoreboard on done.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   cycles;
    int   stim_bad;
    bit   timed_out;
    mode = v.mode;
    e.err  = 8'(v.exp_err);
    e.fail = v.exp_fail;
    e.pass = v.exp_pass;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({v.name, "_busy_rise"}, 32'(busy), 32'd1);
    checkOutput({v.name, "_cleared"}, {20'd0, fail_vec, err_count}, 32'd0);
    checkOutput({v.name, "_pass_low"}, 32'(pass), 32'd0);
    cycles = 0;
    stim_bad = 0;
    timed_out = 0;
    while (busy) begin
      if (stim !== 2'(cycles / 3)) stim_bad++;
      cycles++;
      start = (v.pulse_at != 0 && cycles == v.pulse_at);
      if (cycles > 100) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({v.name, "_timeout"}, 32'(timed_out), 32'd0);
    checkOutput({v.name, "_busy_cycles"}, 32'(cycles), 32'd12);
    checkOutput({v.name, "_stim_seq_errs"}, 32'(stim_bad), 32'd0);
    checkOutput({v.name, "_done"}, 32'(done), 32'd1);
    e = sb_q.pop_front();
    checkOutput({v.name, "_err_count"}, 32'(err_count), 32'(e.err));
    checkOutput({v.name, "_fail_vec"}, 32'(fail_vec), 32'(e.fail));
    checkOutput({v.name, "_pass"}, 32'(pass), 32'(e.pass));
    checkOutput({v.name, "_stim_hold"}, 32'(stim), 32'd3);
    repeat (3) @(negedge clk);
    checkOutput({v.name, "_done_held"}, {30'd0, done, pass}, {30'd0, 1'b1, e.pass});
  endtask

  initial begin
    vecs[0] = '{"and_ok",      0, 0, 4'b0000, 1'b1, 0};
    vecs[1] = '{"stuck0",      1, 1, 4'b1000, 1'b0, 0};
    vecs[2] = '{"or_dut",      2, 2, 4'b0110, 1'b0, 0};
    vecs[3] = '{"busy_start",  0, 0, 4'b0000, 1'b1, 4};
    vecs[4] = '{"xor_dut",     3, 3, 4'b1110, 1'b0, 0};
    vecs[5] = '{"nand_dut",    4, 4, 4'b1111, 1'b0, 0};
    vecs[6] = '{"and_again",   0, 0, 4'b0000, 1'b1, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", {15'd0, stim, busy, done, pass, err_count, fail_vec},
                32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Saturating 1-bit counter against a DUT that is the inverse of the expected AND.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int n = 0;
      while (!done2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("w1_busy_cycles", 32'(n), 32'd12);
    end
    checkOutput("w1_err_sat", 32'(err_count2), 32'd1);
    checkOutput("w1_fail_vec", 32'(fail_vec2), 32'hF);
    checkOutput("w1_pass", 32'(pass2), 32'd0);

    // Reset during the fifth busy cycle of a run that has already logged an error.
    mode = 4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_err", 32'(err_count), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset", {15'd0, stim, busy, done, pass, err_count, fail_vec}, 32'd0);
    @(negedge clk);
    checkOutput("post_reset_idle", {30'd0, busy, done}, 32'd0);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_beats_start", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Synthesizable self-checking stimulus engine for small combinational gates in the gate library. It walks every input combination of an N-input gate in ascending binary order, holds each vector for a programmable settle time, and samples the gate output. It compares each sample against a parameterised truth table, records which vectors failed, and reports a pass/fail verdict. It sits on the DUT's input/output pins as the active driving-and-checking end, so gate checks run on hardware or in long regressions without a printing testbench.

## Interface
- N_IN, default 2: number of DUT inputs; 1..4.
- TRUTH, default 4'b1000: expected output per vector; bit k = expected result for stim == k; width 2**N_IN; default = 2-input AND.
- SETTLE, default 2: cycles each vector is held before sampling; must be ≥1.
- ERR_W, default 8: error counter width.
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a run; sampled only in IDLE or DONE.
- stim, output, N_IN: DUT input vector; for N_IN=2, stim[1]→a, stim[0]→b.
- dut_out, input, 1: DUT output (c).
- busy, output, 1: run in progress.
- done, output, 1: run complete; held until next start or reset.
- pass, output, 1: valid when done; 1 iff err_count == 0.
- err_count, output, ERR_W: mismatches this run; saturates at all-ones.
- fail_vec, output, 2**N_IN: bit k set if vector k mismatched.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE. Encoding is binary.
- IDLE: stim=0, busy=0, done=0. If start=1, go to DRIVE. On the same edge, clear err_count, fail_vec and the settle counter; stim becomes 0.
- DRIVE: busy=1; settle counter increments each cycle. When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE: busy=1. Compare dut_out with TRUTH[stim].
  - On mismatch, set fail_vec[stim] and increment err_count, saturating at all-ones.
  - If stim == 2**N_IN-1, go to DONE and hold stim.
  - Otherwise, stim increments, the counter clears, and the state returns to DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0). stim, err_count and fail_vec hold.
  - start=1 restarts exactly as from IDLE: clears results and goes to DRIVE.
- start while busy is ignored.
- stim never wraps mid-run. The final increment is suppressed.
- pass is a registered flag, only meaningful while done=1. It reads 0 outside DONE.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, state=IDLE.
- Reset mid-run aborts immediately on the next edge. No partial results are retained.
- The start edge causes busy=1 in the following cycle.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE plus 1 in SAMPLE.
- dut_out is sampled at the end of the SAMPLE cycle, i.e. SETTLE+1 edges after stim changed.
- Full run: 2**N_IN × (SETTLE+1) cycles from busy rising to done rising. With the defaults this is 12 cycles.
- err_count and fail_vec update on the SAMPLE edge and are visible the next cycle.
- If the last vector fails, the error is included in err_count, fail_vec and pass when done first asserts.
- start and rst together: rst wins.

## Structure
- Shared package/include (gate_pkg): state encoding localparams (ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE) and the TRUTH constants for the library gates (TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111).
- Single module. No sub-module needed.
- Counter width is $clog2(SETTLE+1).

## Test plan
- Default params, correct AND DUT, pulse start → busy 12 cycles, then done=1, pass=1, err_count=0, fail_vec=4'b0000; stim sequence 0,1,2,3 each held 3 cycles.
- AND TRUTH, DUT stuck-at-0 → done after 12 cycles, pass=0, err_count=1, fail_vec=4'b1000.
- AND TRUTH, DUT is OR → err_count=2, fail_vec=4'b0110, pass=0.
- ERR_W=1, DUT is inverted AND → err_count saturates at 1, fail_vec=4'b1111, pass=0.
- rst asserted in cycle 5 of a run → next cycle all outputs at reset values, state IDLE.
- start re-pulsed while busy → ignored, run ends on cycle 12.
- Second start from DONE → results cleared and full run repeated.
